// File: rtl/data_sram_bridge_pkg.sv
// Shared definitions for the M-stage data SRAM bridge: FSM encoding, access
// size codes and helpers used by both the bridge and its load aligner.
package data_sram_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ADDR = 2'd1,
    WAIT_DATA = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // fcM bit that selects zero- instead of sign-extension on loads
  localparam int ZEXT_BIT = 2;

  // The reserved size code 11 behaves exactly like a word access.
  function automatic logic [1:0] eff_size(input logic [1:0] code);
    return (code == 2'b11) ? SIZE_WORD : code;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      SIZE_HALF: return addr[0];
      SIZE_WORD: return (addr != 2'b00);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a 32-bit read word and sign- or
// zero-extends it; word accesses pass straight through.
module load_align
  import data_sram_bridge_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  fc,
  output logic [31:0] readdata
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        zext;

  always_comb begin
    sel_byte = 8'h00;
    sel_half = 16'h0000;
    zext     = fc[ZEXT_BIT];
    readdata = rdata;

    case (addr)
      2'd0:    sel_byte = rdata[7:0];
      2'd1:    sel_byte = rdata[15:8];
      2'd2:    sel_byte = rdata[23:16];
      default: sel_byte = rdata[31:24];
    endcase

    sel_half = addr[1] ? rdata[31:16] : rdata[15:0];

    case (eff_size(fc[1:0]))
      SIZE_BYTE: readdata = zext ? {24'h000000, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      SIZE_HALF: readdata = zext ? {16'h0000, sel_half} : {{16{sel_half[15]}}, sel_half};
      default:   readdata = rdata;
    endcase
  end

endmodule

// File: rtl/data_sram_bridge.sv
// Bridges the M-stage load/store controls onto an SRAM-like bus, stalling the
// pipeline until the access completes and presenting the aligned load result.
//
// Handshake: a request is accepted in any cycle where data_req and
// data_addr_ok are both 1; its data phase completes in the cycle data_data_ok
// is 1 (possibly the same cycle). Acks seen with no request outstanding are
// ignored. Bus fields are held stable because stallM freezes the M-stage inputs.
module data_sram_bridge
  import data_sram_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [2:0]  fcM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic        advM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        addr_errM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output state_t      dbg_state
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] rdata_q;
  logic        capture;
  logic        access_valid;
  logic [1:0]  size;

  always_comb begin
    access_valid = memreadM | memwriteM;
    size         = eff_size(fcM[1:0]);
    addr_errM    = access_valid & misaligned(size, aluoutM[1:0]);
    // Gating with rst drops the request the instant reset asserts.
    data_req     = rst & (((state == IDLE) & access_valid & ~addr_errM) |
                          (state == WAIT_ADDR));
    stallM       = access_valid & ~addr_errM & (state != DONE);
  end

  always_comb begin
    data_wr   = memwriteM;
    data_addr = aluoutM;
    data_size = size;
    case (size)
      SIZE_BYTE: data_wdata = {4{writedataM[7:0]}};
      SIZE_HALF: data_wdata = {2{writedataM[15:0]}};
      default:   data_wdata = writedataM;
    endcase
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE, WAIT_ADDR: begin
        if (data_req) begin
          if (data_addr_ok) begin
            if (data_data_ok) begin
              state_nxt = DONE;
              capture   = 1'b1;
            end else begin
              state_nxt = WAIT_DATA;
            end
          end else begin
            state_nxt = WAIT_ADDR;
          end
        end
      end
      WAIT_DATA: begin
        if (data_data_ok) begin
          state_nxt = DONE;
          capture   = 1'b1;
        end
      end
      // Hold the result until the pipeline moves on, so nothing reissues.
      DONE: begin
        if (advM) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rdata_q <= 32'h0;
    end else begin
      state <= state_nxt;
      if (capture) rdata_q <= data_rdata;
    end
  end

  load_align u_load_align (
    .rdata    (rdata_q),
    .addr     (aluoutM[1:0]),
    .fc       (fcM),
    .readdata (readdataM)
  );

  assign dbg_state = state;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge: a driver plays pipeline and slave,
// a negedge monitor checks bus requests and load results against queues.
module tb_data_sram_bridge;
  import data_sram_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        memreadM, memwriteM, advM;
  logic [2:0]  fcM;
  logic [31:0] aluoutM, writedataM;
  logic [31:0] readdataM;
  logic        stallM, addr_errM;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  state_t      dbg_state;

  always #5 clk = ~clk;

  data_sram_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .memreadM     (memreadM),
    .memwriteM    (memwriteM),
    .fcM          (fcM),
    .aluoutM      (aluoutM),
    .writedataM   (writedataM),
    .advM         (advM),
    .readdataM    (readdataM),
    .stallM       (stallM),
    .addr_errM    (addr_errM),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .dbg_state    (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // {wr, size, addr, wdata}
  logic [66:0] exp_q[$];
  logic [31:0] exp_rd_q[$];
  logic [66:0] mon_req;
  logic [31:0] mon_rd;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  fc;
    logic [31:0] addr;
    logic [31:0] wd;
    int          ad;
    int          dd;
    int          hold;
    logic [31:0] rdata;
    logic [31:0] exp_rd;
    logic [1:0]  exp_size;
    logic [31:0] exp_wd;
  } vec_t;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: every accepted request and every consumed load result.
  always @(negedge clk) begin
    if (rst && data_req && data_addr_ok) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_request: got addr 0x%08h expected no request", data_addr);
      end else begin
        mon_req = exp_q.pop_front();
        check("req_wr",    32'(data_wr),   32'(mon_req[66]));
        check("req_size",  32'(data_size), 32'(mon_req[65:64]));
        check("req_addr",  data_addr,      mon_req[63:32]);
        check("req_wdata", data_wdata,     mon_req[31:0]);
      end
    end
    if (rst && memreadM && !memwriteM && !addr_errM && !stallM && advM) begin
      if (exp_rd_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_load: got 0x%08h expected no result", readdataM);
      end else begin
        mon_rd = exp_rd_q.pop_front();
        check("readdata", readdataM, mon_rd);
      end
    end
  end

  task automatic do_access(input vec_t v, input string tag);
    int t;
    int acc_t;
    bit acc;
    bit done;
    memreadM   = v.rd;
    memwriteM  = v.wr;
    fcM        = v.fc;
    aluoutM    = v.addr;
    writedataM = v.wd;
    advM       = 1'b0;
    exp_q.push_back({v.wr, v.exp_size, v.addr, v.exp_wd});
    if (v.rd && !v.wr) exp_rd_q.push_back(v.exp_rd);
    t = 0; acc_t = 0; acc = 1'b0; done = 1'b0;
    while (!done && t < 50) begin
      data_addr_ok = !acc && (t >= v.ad);
      data_data_ok = acc ? ((t - acc_t) >= v.dd) : ((t >= v.ad) && (v.dd == 0));
      data_rdata   = data_data_ok ? v.rdata : $urandom();
      @(negedge clk);
      check({tag, "_stall"}, 32'(stallM), 32'd1);
      check({tag, "_req"},   32'(data_req), 32'(!acc));
      check({tag, "_addr"},  data_addr, v.addr);
      if (data_addr_ok && !acc) begin
        acc   = 1'b1;
        acc_t = t;
      end
      if (data_data_ok) done = 1'b1;
      @(posedge clk); #1;
      t++;
    end
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got no data_ok completion expected one within 50 cycles", tag);
    end
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_state"}, 32'(dbg_state), 32'(DONE));
      check({tag, "_hold_stall"}, 32'(stallM), 32'd0);
      check({tag, "_hold_req"},   32'(data_req), 32'd0);
      @(posedge clk); #1;
    end
    advM = 1'b1;
    @(negedge clk);
    check({tag, "_adv_stall"}, 32'(stallM), 32'd0);
    @(posedge clk); #1;
    advM      = 1'b0;
    memreadM  = 1'b0;
    memwriteM = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;
  endtask

  task automatic misaligned_probe(input logic [2:0] fc, input logic [31:0] addr);
    memreadM     = 1'b1;
    memwriteM    = 1'b0;
    fcM          = fc;
    aluoutM      = addr;
    data_addr_ok = 1'b1;
    @(negedge clk);
    check("mis_err",   32'(addr_errM), 32'd1);
    check("mis_req",   32'(data_req),  32'd0);
    check("mis_stall", 32'(stallM),    32'd0);
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    memreadM     = 1'b0;
    @(negedge clk);
    check("mis_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;
  endtask

  vec_t v;

  initial begin
    rst = 1'b0;
    memreadM = 1'b0; memwriteM = 1'b0; advM = 1'b0;
    fcM = 3'b010; aluoutM = 32'h0; writedataM = 32'h0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req",      32'(data_req),  32'd0);
    check("rst_readdata", readdataM,      32'h0);
    check("rst_state",    32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // rd, wr, fc, addr, wd, ad, dd, hold, rdata, exp_rd, exp_size, exp_wd
    v = '{1'b1, 1'b0, 3'b010, 32'h00001000, 32'h0, 0, 2, 1, 32'hDEADBEEF, 32'hDEADBEEF, 2'b10, 32'h0};
    do_access(v, "ld_word");
    v = '{1'b1, 1'b0, 3'b000, 32'h00001003, 32'h0, 0, 0, 1, 32'h80AABBCC, 32'hFFFFFF80, 2'b00, 32'h0};
    do_access(v, "ld_sbyte3");
    v = '{1'b1, 1'b0, 3'b100, 32'h00001003, 32'h0, 1, 1, 0, 32'h80AABBCC, 32'h00000080, 2'b00, 32'h0};
    do_access(v, "ld_zbyte3");
    v = '{1'b1, 1'b0, 3'b000, 32'h00001001, 32'h0, 0, 0, 1, 32'h80AABBCC, 32'hFFFFFFBB, 2'b00, 32'h0};
    do_access(v, "ld_sbyte1");
    v = '{1'b0, 1'b1, 3'b001, 32'h00002002, 32'h12345678, 0, 1, 1, 32'h0, 32'h0, 2'b01, 32'h56785678};
    do_access(v, "st_half");
    v = '{1'b1, 1'b0, 3'b001, 32'h00004002, 32'h0, 3, 1, 4, 32'h80017FFF, 32'hFFFF8001, 2'b01, 32'h0};
    do_access(v, "ld_shalf_slow");
    v = '{1'b0, 1'b1, 3'b000, 32'h00005001, 32'hFFFF12A5, 2, 0, 1, 32'h0, 32'h0, 2'b00, 32'hA5A5A5A5};
    do_access(v, "st_byte");
    v = '{1'b1, 1'b0, 3'b011, 32'h00006004, 32'h0, 0, 0, 0, 32'h13572468, 32'h13572468, 2'b10, 32'h0};
    do_access(v, "ld_rsvd");
    v = '{1'b1, 1'b0, 3'b101, 32'h00007000, 32'h0, 1, 2, 2, 32'h12349ABC, 32'h00009ABC, 2'b01, 32'h0};
    do_access(v, "ld_zhalf");
    v = '{1'b1, 1'b1, 3'b010, 32'h00008000, 32'hCAFEF00D, 1, 0, 1, 32'h0, 32'h0, 2'b10, 32'hCAFEF00D};
    do_access(v, "rdwr_store");
    v = '{1'b0, 1'b1, 3'b001, 32'h00000000, 32'hABCD1234, 0, 0, 0, 32'h0, 32'h0, 2'b01, 32'h12341234};
    do_access(v, "st_half0");

    misaligned_probe(3'b010, 32'h00003001);
    misaligned_probe(3'b001, 32'h00003003);
    misaligned_probe(3'b011, 32'h00003002);
    misaligned_probe(3'b101, 32'h00003001);

    // Stray acks with nothing outstanding must not move the FSM.
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h77777777;
    repeat (2) begin
      @(negedge clk);
      check("stray_state", 32'(dbg_state), 32'(IDLE));
      check("stray_req",   32'(data_req),  32'd0);
      @(posedge clk); #1;
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b0;

    // Reset while in WAIT_DATA, then a stale data_ok.
    memreadM = 1'b1; fcM = 3'b010; aluoutM = 32'h00009000; writedataM = 32'h0;
    exp_q.push_back({1'b0, 2'b10, 32'h00009000, 32'h0});
    data_addr_ok = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    @(negedge clk);
    check("mid_state", 32'(dbg_state), 32'(WAIT_DATA));
    check("mid_stall", 32'(stallM),    32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_req",      32'(data_req),  32'd0);
    check("mid_rst_state",    32'(dbg_state), 32'(IDLE));
    check("mid_rst_readdata", readdataM,      32'h0);
    @(posedge clk); #1;
    memreadM = 1'b0;
    rst = 1'b1;
    data_data_ok = 1'b1; data_rdata = 32'h55555555;
    repeat (2) begin
      @(negedge clk);
      check("stale_state",    32'(dbg_state), 32'(IDLE));
      check("stale_readdata", readdataM,      32'h0);
      @(posedge clk); #1;
    end
    data_data_ok = 1'b0;
    @(negedge clk);

    check("req_queue_empty",  32'(exp_q.size()),    32'd0);
    check("load_queue_empty", 32'(exp_rd_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
